// File: rtl/drop_sequencer_if.sv
// Game-side framebuffer access port: request/grant handshake plus a single-cell read/write bus.
interface drop_sequencer_if;
  logic       fb_req;
  logic       fb_gnt;
  logic       fb_we;
  logic [3:0] fb_x;
  logic [3:0] fb_y;
  logic [1:0] fb_wdata;
  logic [1:0] fb_rdata;

  modport master (
    output fb_req, fb_we, fb_x, fb_y, fb_wdata,
    input  fb_gnt, fb_rdata
  );

  modport slave (
    input  fb_req, fb_we, fb_x, fb_y, fb_wdata,
    output fb_gnt, fb_rdata
  );
endinterface

// File: rtl/drop_sequencer.sv
// Falling 1x1 tetris piece sequencer on a 16x16 framebuffer: spawn, drop on tick,
// shift on request, land on collision, sticky game over when the spawn cell is taken.
module drop_sequencer #(
  parameter logic [3:0] SPAWN_X     = 4'd3,
  parameter logic [3:0] SPAWN_Y     = 4'd15,
  parameter logic [1:0] PIECE_LEVEL = 2'd3
) (
  input  logic                      clk,
  input  logic                      rst,
  drop_sequencer_if.master          fb,
  input  logic                      i_start,
  input  logic                      i_tick,
  input  logic                      i_move_left,
  input  logic                      i_move_right,
  output logic [3:0]                o_piece_x,
  output logic [3:0]                o_piece_y,
  output logic                      o_landed,
  output logic [7:0]                o_land_count,
  output logic                      o_game_over
);

  typedef enum logic [3:0] {
    S_IDLE, S_SP_RD, S_SP_EV, S_SP_WR, S_FALL,
    S_CK_RD, S_CK_EV, S_ERASE, S_DRAW, S_LAND, S_OVER
  } state_t;

  state_t     r_state;
  logic       r_req;
  logic       r_we;
  logic [3:0] r_x;
  logic [3:0] r_y;
  logic [1:0] r_wdata;
  logic [3:0] r_piece_x;
  logic [3:0] r_piece_y;
  logic [3:0] r_tgt_x;
  logic [3:0] r_tgt_y;
  logic       r_is_drop;
  logic       r_tick_pend;
  logic       r_landed;
  logic [7:0] r_land_count;
  logic       r_game_over;

  logic w_drop;
  logic w_left;
  logic w_right;
  logic w_tick_latch;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_drop  = i_tick | r_tick_pend;
  // Simultaneous left+right cancel each other; edge moves are never issued.
  assign w_left  = i_move_left  & ~i_move_right & (r_piece_x != 4'd0);
  assign w_right = i_move_right & ~i_move_left  & (r_piece_x != 4'd15);
  assign w_tick_latch = i_tick & (r_state != S_IDLE) & (r_state != S_FALL) & (r_state != S_OVER);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_x          <= 4'd0;
      r_y          <= 4'd0;
      r_wdata      <= 2'd0;
      r_piece_x    <= SPAWN_X;
      r_piece_y    <= SPAWN_Y;
      r_tick_pend  <= 1'b0;
      r_landed     <= 1'b0;
      r_land_count <= 8'd0;
      r_game_over  <= 1'b0;
    end else begin
      r_landed <= 1'b0;
      if (w_tick_latch) r_tick_pend <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_SP_RD;
            r_req   <= 1'b1;
            r_we    <= 1'b0;
            r_x     <= SPAWN_X;
            r_y     <= SPAWN_Y;
          end
        end

        S_SP_RD: begin
          if (fb.fb_gnt) begin
            r_req   <= 1'b0;
            r_state <= S_SP_EV;
          end
        end

        S_SP_EV: begin
          if (fb.fb_rdata != 2'd0) begin
            r_state     <= S_OVER;
            r_game_over <= 1'b1;
          end else begin
            r_state <= S_SP_WR;
            r_req   <= 1'b1;
            r_we    <= 1'b1;
            r_wdata <= PIECE_LEVEL;
          end
        end

        S_SP_WR: begin
          if (fb.fb_gnt) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_wdata   <= 2'd0;
            r_piece_x <= SPAWN_X;
            r_piece_y <= SPAWN_Y;
            r_state   <= S_FALL;
          end
        end

        S_FALL: begin
          if (w_drop) begin
            r_tick_pend <= 1'b0;
            if (r_piece_y == 4'd0) begin
              r_state <= S_LAND;
            end else begin
              r_tgt_x   <= r_piece_x;
              r_tgt_y   <= r_piece_y - 4'd1;
              r_is_drop <= 1'b1;
              r_req     <= 1'b1;
              r_we      <= 1'b0;
              r_x       <= r_piece_x;
              r_y       <= r_piece_y - 4'd1;
              r_state   <= S_CK_RD;
            end
          end else if (w_left || w_right) begin
            r_tgt_x   <= w_left ? r_piece_x - 4'd1 : r_piece_x + 4'd1;
            r_tgt_y   <= r_piece_y;
            r_is_drop <= 1'b0;
            r_req     <= 1'b1;
            r_we      <= 1'b0;
            r_x       <= w_left ? r_piece_x - 4'd1 : r_piece_x + 4'd1;
            r_y       <= r_piece_y;
            r_state   <= S_CK_RD;
          end
        end

        S_CK_RD: begin
          if (fb.fb_gnt) begin
            r_req   <= 1'b0;
            r_state <= S_CK_EV;
          end
        end

        S_CK_EV: begin
          if (fb.fb_rdata != 2'd0) begin
            r_state <= r_is_drop ? S_LAND : S_FALL;
          end else begin
            r_req   <= 1'b1;
            r_we    <= 1'b1;
            r_x     <= r_piece_x;
            r_y     <= r_piece_y;
            r_wdata <= 2'd0;
            r_state <= S_ERASE;
          end
        end

        // Erase and draw run back-to-back, so fb_req stays high across the pair.
        S_ERASE: begin
          if (fb.fb_gnt) begin
            r_x     <= r_tgt_x;
            r_y     <= r_tgt_y;
            r_wdata <= PIECE_LEVEL;
            r_state <= S_DRAW;
          end
        end

        S_DRAW: begin
          if (fb.fb_gnt) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_wdata   <= 2'd0;
            r_piece_x <= r_tgt_x;
            r_piece_y <= r_tgt_y;
            r_state   <= S_FALL;
          end
        end

        S_LAND: begin
          r_landed     <= 1'b1;
          r_land_count <= sat_inc(r_land_count);
          r_req        <= 1'b1;
          r_we         <= 1'b0;
          r_x          <= SPAWN_X;
          r_y          <= SPAWN_Y;
          r_state      <= S_SP_RD;
        end

        S_OVER: begin
          r_req <= 1'b0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fb.fb_req    = r_req;
  assign fb.fb_we     = r_we;
  assign fb.fb_x      = r_x;
  assign fb.fb_y      = r_y;
  assign fb.fb_wdata  = r_wdata;
  assign o_piece_x    = r_piece_x;
  assign o_piece_y    = r_piece_y;
  assign o_landed     = r_landed;
  assign o_land_count = r_land_count;
  assign o_game_over  = r_game_over;

endmodule

// File: tb/tb_drop_sequencer.sv
// Bench for drop_sequencer: framebuffer model plus a scoreboard of expected bus accesses.
module tb_drop_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic       i_tick = 1'b0;
  logic       i_move_left = 1'b0;
  logic       i_move_right = 1'b0;
  logic       gnt_en = 1'b1;
  logic [3:0] o_piece_x;
  logic [3:0] o_piece_y;
  logic       o_landed;
  logic [7:0] o_land_count;
  logic       o_game_over;

  int n_chk  = 0;
  int n_pass = 0;

  drop_sequencer_if bus();

  drop_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .fb           (bus.master),
    .i_start      (i_start),
    .i_tick       (i_tick),
    .i_move_left  (i_move_left),
    .i_move_right (i_move_right),
    .o_piece_x    (o_piece_x),
    .o_piece_y    (o_piece_y),
    .o_landed     (o_landed),
    .o_land_count (o_land_count),
    .o_game_over  (o_game_over)
  );

  always #5 clk = ~clk;

  // Framebuffer model: writes commit on the granted cycle, read data appears the cycle after.
  logic [1:0] mem [16][16];
  logic       tb_clr = 1'b0;
  logic       tb_wr  = 1'b0;
  logic [3:0] tb_wx  = 4'd0;
  logic [3:0] tb_wy  = 4'd0;
  logic [1:0] tb_wd  = 2'd0;

  assign bus.fb_gnt = bus.fb_req & gnt_en;

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          mem[a][b] <= 2'd0;
    end else if (tb_wr) begin
      mem[tb_wx][tb_wy] <= tb_wd;
    end
    if (bus.fb_req && bus.fb_gnt) begin
      if (bus.fb_we) mem[bus.fb_x][bus.fb_y] <= bus.fb_wdata;
      else           bus.fb_rdata <= mem[bus.fb_x][bus.fb_y];
    end
  end

  // Scoreboard of {we, x, y, wdata}
  logic [10:0] exp_q[$];
  logic [10:0] mon_got;
  logic [10:0] mon_exp;

  always @(negedge clk) begin
    if (bus.fb_req && bus.fb_gnt) begin
      mon_got = {bus.fb_we, bus.fb_x, bus.fb_y, bus.fb_wdata};
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL bus_unexpected got we=%0d x=%0d y=%0d d=%0d required no access",
                 mon_got[10], mon_got[9:6], mon_got[5:2], mon_got[1:0]);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got == mon_exp) n_pass++;
        else $display("FAIL bus_access got we=%0d x=%0d y=%0d d=%0d required we=%0d x=%0d y=%0d d=%0d",
                      mon_got[10], mon_got[9:6], mon_got[5:2], mon_got[1:0],
                      mon_exp[10], mon_exp[9:6], mon_exp[5:2], mon_exp[1:0]);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s got %0d required %0d", nm, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic exp_rd(input logic [3:0] x, input logic [3:0] y);
    exp_q.push_back({1'b0, x, y, 2'd0});
  endtask

  task automatic exp_wr(input logic [3:0] x, input logic [3:0] y, input logic [1:0] d);
    exp_q.push_back({1'b1, x, y, d});
  endtask

  task automatic board_clear();
    tb_clr = 1'b1; step(); tb_clr = 1'b0;
  endtask

  task automatic board_set(input logic [3:0] x, input logic [3:0] y, input logic [1:0] d);
    tb_wx = x; tb_wy = y; tb_wd = d; tb_wr = 1'b1; step(); tb_wr = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; step(); step(); rst = 1'b0; step();
  endtask

  task automatic pulse_start(); i_start = 1'b1; step(); i_start = 1'b0; endtask
  task automatic pulse_tick();  i_tick  = 1'b1; step(); i_tick  = 1'b0; endtask

  task automatic spawn();
    exp_rd(4'd3, 4'd15); exp_wr(4'd3, 4'd15, 2'd3);
    pulse_start(); wait_n(8);
  endtask

  task automatic drop(input logic [3:0] x, input logic [3:0] y);
    exp_rd(x, y - 4'd1); exp_wr(x, y, 2'd0); exp_wr(x, y - 4'd1, 2'd3);
    pulse_tick(); wait_n(8);
  endtask

  task automatic wait_landed(input string nm);
    int seen;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (o_landed) seen++;
      step();
    end
    chk(nm, seen, 1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   int'(bus.fb_req), 0);
    chk({tag, "_we"},    int'(bus.fb_we), 0);
    chk({tag, "_x"},     int'(bus.fb_x), 0);
    chk({tag, "_y"},     int'(bus.fb_y), 0);
    chk({tag, "_wdata"}, int'(bus.fb_wdata), 0);
    chk({tag, "_px"},    int'(o_piece_x), 3);
    chk({tag, "_py"},    int'(o_piece_y), 15);
    chk({tag, "_landed"}, int'(o_landed), 0);
    chk({tag, "_count"}, int'(o_land_count), 0);
    chk({tag, "_over"},  int'(o_game_over), 0);
  endtask

  initial begin
    logic [3:0] sx, sy;
    logic       swe;
    int         stable;
    int         found;

    board_clear();
    step(); step();
    chk_reset("rst0");
    rst = 1'b0; step();

    // Empty board: full fall, then land and respawn
    spawn();
    chk("t1_spawn_y", int'(o_piece_y), 15);
    for (int y = 15; y >= 1; y--) begin
      drop(4'd3, 4'(y));
      chk("t1_py", int'(o_piece_y), y - 1);
    end
    chk("t1_px", int'(o_piece_x), 3);
    exp_rd(4'd3, 4'd15); exp_wr(4'd3, 4'd15, 2'd3);
    pulse_tick();
    wait_landed("t1_landed");
    chk("t1_count", int'(o_land_count), 1);
    chk("t1_floor", int'(mem[3][0]), 3);
    chk("t1_respawn_y", int'(o_piece_y), 15);

    // Obstacle at (3,7): land at y=8
    board_clear();
    board_set(4'd3, 4'd7, 2'd3);
    reset_dut();
    spawn();
    for (int y = 15; y >= 9; y--) drop(4'd3, 4'(y));
    chk("t2_py", int'(o_piece_y), 8);
    exp_rd(4'd3, 4'd7); exp_rd(4'd3, 4'd15); exp_wr(4'd3, 4'd15, 2'd3);
    pulse_tick();
    wait_landed("t2_landed");
    chk("t2_count", int'(o_land_count), 1);
    chk("t2_obst", int'(mem[3][7]), 3);
    chk("t2_rest", int'(mem[3][8]), 3);

    // Spawn cell occupied: game over, bus stays idle
    board_set(4'd3, 4'd15, 2'd2);
    reset_dut();
    exp_rd(4'd3, 4'd15);
    pulse_start(); wait_n(6);
    chk("t3_over", int'(o_game_over), 1);
    chk("t3_req", int'(bus.fb_req), 0);
    pulse_start(); pulse_tick(); wait_n(8);
    chk("t3_req_after", int'(bus.fb_req), 0);
    chk("t3_over_hold", int'(o_game_over), 1);
    chk("t3_q_empty", exp_q.size(), 0);

    // Left edge: move ignored, then move right
    board_clear();
    reset_dut();
    spawn();
    for (int x = 3; x >= 1; x--) begin
      exp_rd(4'(x - 1), 4'd15); exp_wr(4'(x), 4'd15, 2'd0); exp_wr(4'(x - 1), 4'd15, 2'd3);
      i_move_left = 1'b1; step(); i_move_left = 1'b0; wait_n(8);
    end
    chk("t4_px0", int'(o_piece_x), 0);
    i_move_left = 1'b1; step(); i_move_left = 1'b0; wait_n(8);
    chk("t4_edge_px", int'(o_piece_x), 0);
    chk("t4_edge_q", exp_q.size(), 0);
    exp_rd(4'd1, 4'd15); exp_wr(4'd0, 4'd15, 2'd0); exp_wr(4'd1, 4'd15, 2'd3);
    i_move_right = 1'b1; step(); i_move_right = 1'b0; wait_n(8);
    chk("t4_px1", int'(o_piece_x), 1);

    // Stalled grant during check read, two ticks pending -> one extra drop
    gnt_en = 1'b0;
    exp_rd(4'd1, 4'd14);
    pulse_tick();
    sx = bus.fb_x; sy = bus.fb_y; swe = bus.fb_we;
    stable = 1;
    for (int k = 0; k < 10; k++) begin
      i_tick = (k == 2 || k == 5);
      step();
      if (bus.fb_x != sx || bus.fb_y != sy || bus.fb_we != swe || !bus.fb_req) stable = 0;
    end
    i_tick = 1'b0;
    chk("t5_stable", stable, 1);
    chk("t5_hold_x", int'(bus.fb_x), 1);
    chk("t5_hold_y", int'(bus.fb_y), 14);
    exp_wr(4'd1, 4'd15, 2'd0); exp_wr(4'd1, 4'd14, 2'd3);
    exp_rd(4'd1, 4'd13); exp_wr(4'd1, 4'd14, 2'd0); exp_wr(4'd1, 4'd13, 2'd3);
    gnt_en = 1'b1;
    wait_n(20);
    chk("t5_py", int'(o_piece_y), 13);
    chk("t5_q_empty", exp_q.size(), 0);

    // Tick wins over a simultaneous move
    exp_rd(4'd1, 4'd12); exp_wr(4'd1, 4'd13, 2'd0); exp_wr(4'd1, 4'd12, 2'd3);
    i_tick = 1'b1; i_move_right = 1'b1; step(); i_tick = 1'b0; i_move_right = 1'b0;
    wait_n(8);
    chk("t6_px", int'(o_piece_x), 1);
    chk("t6_py", int'(o_piece_y), 12);

    // Reset while the erase write is waiting for grant
    exp_rd(4'd1, 4'd11);
    pulse_tick();
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      if (bus.fb_req && bus.fb_we) begin
        gnt_en = 1'b0;
        rst = 1'b1;
        found = 1;
      end else begin
        step();
      end
    end
    chk("t6_erase_seen", found, 1);
    step();
    chk_reset("t6_rst");
    rst = 1'b0; gnt_en = 1'b1;
    wait_n(4);
    chk("t6_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
